// File: rtl/mem_arbiter_rv_pkg.sv
// Shared state encoding, access sizes and exception codes for the RV memory arbiter.
package mem_arbiter_rv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DATA  = 2'd2,
        ST_DONE  = 2'd3
    } arbState_t;

    localparam logic [1:0] MEM_ACCESS_BYTE      = 2'b00;
    localparam logic [1:0] MEM_ACCESS_HALF_WORD = 2'b01;
    localparam logic [1:0] MEM_ACCESS_WORD      = 2'b10;

    localparam logic [3:0] EXCEPTION_SUCCESS       = 4'd0;
    localparam logic [3:0] EXCEPTION_ILLEGAL_INSTR = 4'd2;
    localparam logic [3:0] EXCEPTION_MISALIGNED    = 4'd4;
    localparam logic [3:0] EXCEPTION_BUS_ERROR     = 4'd5;

    // Byte offset after forcing natural alignment for the access size.
    function automatic logic [1:0] alignOffset(input logic [1:0] access, input logic [1:0] offset);
        logic [1:0] aligned;
        aligned = offset;
        case (access)
            MEM_ACCESS_HALF_WORD: aligned = {offset[1], 1'b0};
            MEM_ACCESS_WORD:      aligned = 2'b00;
            default:              aligned = offset;
        endcase
        return aligned;
    endfunction

endpackage

// File: rtl/mem_arbiter_rv_lane.sv
// Byte-lane unit: write-data replication and byte enables, read-lane extraction and extension.
// Purely combinational so it can be exercised on its own.
module mem_arbiter_rv_lane
    import mem_arbiter_rv_pkg::*;
(
    input  logic [1:0]  iwAccess,
    input  logic [1:0]  iwOffset,
    input  logic        iwSignExtend,
    input  logic [31:0] iwWData,
    input  logic [31:0] iwRWord,
    output logic [31:0] owWData,
    output logic [3:0]  owByteEn,
    output logic [31:0] owRData
);

    logic [15:0] wLane;

    always_comb begin
        wLane    = 16'(iwRWord >> {iwOffset, 3'b000});
        owWData  = iwWData;
        owByteEn = 4'b1111;
        owRData  = iwRWord;
        case (iwAccess)
            MEM_ACCESS_BYTE: begin
                owWData  = {4{iwWData[7:0]}};
                owByteEn = 4'b0001 << iwOffset;
                owRData  = {{24{iwSignExtend & wLane[7]}}, wLane[7:0]};
            end
            MEM_ACCESS_HALF_WORD: begin
                owWData  = {2{iwWData[15:0]}};
                owByteEn = 4'b0011 << {iwOffset[1], 1'b0};
                owRData  = {{16{iwSignExtend & wLane[15]}}, wLane};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_arbiter_rv.sv
// Shares one variable-latency memory port between instruction fetch and load/store.
// Build option RV_MISALIGN_EXCEPTION_EN traps misaligned half/word accesses instead of aligning them.
//
// state    | meaning
// ST_IDLE  | waiting for a request, round-robin grant
// ST_FETCH | instruction fetch in flight on the memory port
// ST_DATA  | load/store in flight on the memory port
// ST_DONE  | done pulse cycle, requests ignored
module mem_arbiter_rv
    import mem_arbiter_rv_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        iwClk,
    input  logic        iwnRst,
    input  logic        iwIFetchReq,
    input  logic [31:0] iwIFetchAddr,
    output logic        owIFetchDone,
    output logic [31:0] orIFetchData,
    input  logic        iwDReq,
    input  logic        iwDWrite,
    input  logic [31:0] iwDAddr,
    input  logic [31:0] iwDWData,
    input  logic [1:0]  iwDAccess,
    input  logic        iwDSignExtend,
    output logic        owDDone,
    output logic [31:0] orDRData,
    output logic [3:0]  orDException,
    output logic        owMemReq,
    output logic        owMemWrite,
    output logic [31:0] owMemAddr,
    output logic [31:0] owMemWData,
    output logic [3:0]  owMemByteEn,
    input  logic        iwMemAck,
    input  logic [31:0] iwMemRData
);

    localparam bit         TIMER_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT_CYCLES - 1);

    arbState_t  rState, wNextState;
    logic       rLastData;
    logic [7:0] rTimer;
    logic [1:0] rAccess, rOffset;
    logic       rSignExtend;

    logic        wGrantFetch, wGrantData, wAck, wTimeout, wFinish, wInFlight, wTimerHit;
    logic        wReject;
    logic [3:0]  wRejectCode;
    logic [1:0]  wLaneAccess, wLaneOffset;
    logic        wLaneSignExtend;
    logic [31:0] wLaneWData, wLaneRData;
    logic [3:0]  wLaneByteEn;

    assign wInFlight = (rState == ST_FETCH) || (rState == ST_DATA);
    assign wTimerHit = TIMER_EN && (rTimer == TIMER_LAST);

    always_comb begin
        wReject     = 1'b0;
        wRejectCode = EXCEPTION_SUCCESS;
        if (iwDAccess == 2'b11) begin
            wReject     = 1'b1;
            wRejectCode = EXCEPTION_ILLEGAL_INSTR;
        end
`ifdef RV_MISALIGN_EXCEPTION_EN
        else if (alignOffset(iwDAccess, iwDAddr[1:0]) != iwDAddr[1:0]) begin
            wReject     = 1'b1;
            wRejectCode = EXCEPTION_MISALIGNED;
        end
`else
        else begin
            wReject     = 1'b0;
            wRejectCode = EXCEPTION_SUCCESS;
        end
`endif
    end

    // Lane unit sees the live request while idle (write path) and the captured one in flight (read path).
    always_comb begin
        if (rState == ST_IDLE) begin
            wLaneAccess     = iwDAccess;
            wLaneOffset     = alignOffset(iwDAccess, iwDAddr[1:0]);
            wLaneSignExtend = iwDSignExtend;
        end else begin
            wLaneAccess     = rAccess;
            wLaneOffset     = rOffset;
            wLaneSignExtend = rSignExtend;
        end
    end

    mem_arbiter_rv_lane uLane (
        .iwAccess     (wLaneAccess),
        .iwOffset     (wLaneOffset),
        .iwSignExtend (wLaneSignExtend),
        .iwWData      (iwDWData),
        .iwRWord      (iwMemRData),
        .owWData      (wLaneWData),
        .owByteEn     (wLaneByteEn),
        .owRData      (wLaneRData)
    );

    always_comb begin
        wNextState  = rState;
        wGrantFetch = 1'b0;
        wGrantData  = 1'b0;
        wAck        = 1'b0;
        wTimeout    = 1'b0;
        case (rState)
            ST_IDLE: begin
                if (iwDReq && (!iwIFetchReq || !rLastData)) begin
                    wGrantData = 1'b1;
                    wNextState = wReject ? ST_DONE : ST_DATA;
                end else if (iwIFetchReq) begin
                    wGrantFetch = 1'b1;
                    wNextState  = ST_FETCH;
                end
            end
            ST_FETCH, ST_DATA: begin
                if (iwMemAck) begin
                    wAck       = 1'b1;
                    wNextState = ST_DONE;
                end else if (wTimerHit) begin
                    wTimeout   = 1'b1;
                    wNextState = ST_DONE;
                end
            end
            ST_DONE: wNextState = ST_IDLE;
            default: wNextState = ST_IDLE;
        endcase
    end

    assign wFinish = wAck || wTimeout;

    always_ff @(posedge iwClk) begin
        if (!iwnRst) begin
            rState       <= ST_IDLE;
            rLastData    <= 1'b0;
            rTimer       <= '0;
            rAccess      <= MEM_ACCESS_BYTE;
            rOffset      <= '0;
            rSignExtend  <= 1'b0;
            owIFetchDone <= 1'b0;
            orIFetchData <= '0;
            owDDone      <= 1'b0;
            orDRData     <= '0;
            orDException <= EXCEPTION_SUCCESS;
            owMemReq     <= 1'b0;
            owMemWrite   <= 1'b0;
            owMemAddr    <= '0;
            owMemWData   <= '0;
            owMemByteEn  <= '0;
        end else begin
            rState       <= wNextState;
            owIFetchDone <= 1'b0;
            owDDone      <= 1'b0;

            if (wInFlight && !iwMemAck && !wTimerHit && (rTimer != 8'hFF))
                rTimer <= rTimer + 8'd1;

            if (wGrantFetch) begin
                rLastData   <= 1'b0;
                rTimer      <= '0;
                owMemReq    <= 1'b1;
                owMemWrite  <= 1'b0;
                owMemAddr   <= iwIFetchAddr & 32'hFFFF_FFFC;
                owMemWData  <= '0;
                owMemByteEn <= 4'b1111;
            end

            if (wGrantData) begin
                rLastData   <= 1'b1;
                rTimer      <= '0;
                rAccess     <= iwDAccess;
                rOffset     <= alignOffset(iwDAccess, iwDAddr[1:0]);
                rSignExtend <= iwDSignExtend;
                if (wReject) begin
                    owDDone      <= 1'b1;
                    orDRData     <= '0;
                    orDException <= wRejectCode;
                end else begin
                    owMemReq    <= 1'b1;
                    owMemWrite  <= iwDWrite;
                    owMemAddr   <= iwDAddr & 32'hFFFF_FFFC;
                    owMemWData  <= wLaneWData;
                    owMemByteEn <= wLaneByteEn;
                end
            end

            // A timed-out access completes like an acked one but with zero data.
            if (wFinish) begin
                owMemReq <= 1'b0;
                if (rState == ST_FETCH) begin
                    owIFetchDone <= 1'b1;
                    orIFetchData <= wAck ? iwMemRData : '0;
                end else begin
                    owDDone      <= 1'b1;
                    orDRData     <= (wAck && !owMemWrite) ? wLaneRData : '0;
                    orDException <= wAck ? EXCEPTION_SUCCESS : EXCEPTION_BUS_ERROR;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter_rv.sv
// Self-checking bench for mem_arbiter_rv: per-cycle reference model plus directed literal checks.
module tb_mem_arbiter_rv;
    import mem_arbiter_rv_pkg::*;

    localparam int TO = 4;

    logic        iwClk = 1'b0;
    logic        iwnRst = 1'b0;
    logic        iwIFetchReq = 1'b0;
    logic [31:0] iwIFetchAddr = '0;
    logic        iwDReq = 1'b0;
    logic        iwDWrite = 1'b0;
    logic [31:0] iwDAddr = '0;
    logic [31:0] iwDWData = '0;
    logic [1:0]  iwDAccess = 2'b00;
    logic        iwDSignExtend = 1'b0;
    logic        iwMemAck = 1'b0;
    logic [31:0] iwMemRData = '0;
    logic        owIFetchDone, owDDone, owMemReq, owMemWrite;
    logic [31:0] orIFetchData, orDRData, owMemAddr, owMemWData;
    logic [3:0]  orDException, owMemByteEn;

    always #5 iwClk = ~iwClk;

    mem_arbiter_rv #(.TIMEOUT_CYCLES(TO)) dut (
        .iwClk(iwClk), .iwnRst(iwnRst),
        .iwIFetchReq(iwIFetchReq), .iwIFetchAddr(iwIFetchAddr),
        .owIFetchDone(owIFetchDone), .orIFetchData(orIFetchData),
        .iwDReq(iwDReq), .iwDWrite(iwDWrite), .iwDAddr(iwDAddr), .iwDWData(iwDWData),
        .iwDAccess(iwDAccess), .iwDSignExtend(iwDSignExtend),
        .owDDone(owDDone), .orDRData(orDRData), .orDException(orDException),
        .owMemReq(owMemReq), .owMemWrite(owMemWrite), .owMemAddr(owMemAddr),
        .owMemWData(owMemWData), .owMemByteEn(owMemByteEn),
        .iwMemAck(iwMemAck), .iwMemRData(iwMemRData)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // ---------------- arithmetic model of the access rules ----------------
    function automatic logic [31:0] accSize(input logic [1:0] acc);
        if (acc == 2'b00) return 32'd1;
        if (acc == 2'b01) return 32'd2;
        return 32'd4;
    endfunction

    function automatic logic [31:0] effAddr(input logic [1:0] acc, input logic [31:0] a);
        return a - (a % accSize(acc));
    endfunction

    function automatic logic [3:0] expByteEn(input logic [1:0] acc, input logic [31:0] a);
        logic [31:0] sh;
        sh = effAddr(acc, a) % 4;
        if (accSize(acc) == 1) return 4'(32'd1 << sh);
        if (accSize(acc) == 2) return 4'(32'd3 << sh);
        return 4'hF;
    endfunction

    function automatic logic [31:0] expWData(input logic [1:0] acc, input logic [31:0] d);
        if (accSize(acc) == 1) return (d % 256) * 32'h0101_0101;
        if (accSize(acc) == 2) return (d % 65536) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] expRead(input logic [1:0] acc, input logic [31:0] a,
                                            input logic [31:0] word, input bit sx);
        logic [31:0] v, limit;
        if (accSize(acc) == 4) return word;
        limit = 32'd1 << (8 * accSize(acc));
        v = (word >> (8 * (effAddr(acc, a) % 4))) % limit;
        if (sx && v >= limit / 2) v = v - limit;
        return v;
    endfunction

    function automatic bit isMisaligned(input logic [1:0] acc, input logic [31:0] a);
        return (a % accSize(acc)) != 0;
    endfunction

    // ---------------- per-cycle reference model ----------------
    bit          modelValid = 0;
    int          mOwner = 0;      // 0 none, 1 fetch, 2 data
    bit          mFinishing = 0, mLastData = 0;
    int          mWaited = 0;
    logic [31:0] mReqAddr = '0;
    logic [1:0]  mAcc = 2'b00;
    bit          mSx = 0, mWr = 0;
    logic        eMemReq = 0, eMemWrite = 0, eFDone = 0, eDDone = 0, eIsData = 0;
    logic [31:0] eMemAddr = '0, eMemWData = '0, eFData = '0, eDData = '0;
    logic [3:0]  eMemByteEn = '0, eDExc = '0;

    always @(posedge iwClk) begin
        eFDone = 0;
        eDDone = 0;
        if (!iwnRst) begin
            modelValid = 1;
            mOwner = 0; mFinishing = 0; mLastData = 0;
            eMemReq = 0; eMemWrite = 0; eMemAddr = 0; eMemWData = 0; eMemByteEn = 0;
            eFData = 0; eDData = 0; eDExc = EXCEPTION_SUCCESS; eIsData = 0;
        end else if (mFinishing) begin
            mFinishing = 0;
        end else if (mOwner == 0) begin
            if (iwDReq && (!iwIFetchReq || !mLastData)) begin
                mLastData = 1;
                mReqAddr = iwDAddr; mAcc = iwDAccess; mSx = iwDSignExtend; mWr = iwDWrite;
                if (iwDAccess == 2'b11) begin
                    eDDone = 1; eDData = 0; eDExc = EXCEPTION_ILLEGAL_INSTR; mFinishing = 1;
                end
`ifdef RV_MISALIGN_EXCEPTION_EN
                else if (isMisaligned(iwDAccess, iwDAddr)) begin
                    eDDone = 1; eDData = 0; eDExc = EXCEPTION_MISALIGNED; mFinishing = 1;
                end
`endif
                else begin
                    mOwner = 2; mWaited = 0; eIsData = 1;
                    eMemReq = 1; eMemWrite = iwDWrite;
                    eMemAddr = effAddr(iwDAccess, iwDAddr) - (effAddr(iwDAccess, iwDAddr) % 4);
                    eMemWData = expWData(iwDAccess, iwDWData);
                    eMemByteEn = expByteEn(iwDAccess, iwDAddr);
                end
            end else if (iwIFetchReq) begin
                mLastData = 0;
                mOwner = 1; mWaited = 0; eIsData = 0;
                eMemReq = 1; eMemWrite = 0;
                eMemAddr = iwIFetchAddr - (iwIFetchAddr % 4);
            end
        end else begin
            bit ok, fin;
            ok = iwMemAck;
            fin = iwMemAck;
            if (!iwMemAck) begin
                mWaited++;
                if (TO != 0 && mWaited >= TO) fin = 1;
            end
            if (fin) begin
                eMemReq = 0;
                if (mOwner == 1) begin
                    eFDone = 1; eFData = ok ? iwMemRData : 32'd0;
                end else begin
                    eDDone = 1;
                    eDData = (ok && !mWr) ? expRead(mAcc, mReqAddr, iwMemRData, mSx) : 32'd0;
                    eDExc  = ok ? EXCEPTION_SUCCESS : EXCEPTION_BUS_ERROR;
                end
                mOwner = 0;
                mFinishing = 1;
            end
        end
    end

    always @(negedge iwClk) begin
        if (modelValid) begin
            chk("memReq", owMemReq, eMemReq);
            chk("fetchDone", owIFetchDone, eFDone);
            chk("dataDone", owDDone, eDDone);
            if (eMemReq) begin
                chk("memWrite", owMemWrite, eMemWrite);
                chk("memAddr", owMemAddr, eMemAddr);
                if (eIsData) begin
                    chk("memByteEn", owMemByteEn, eMemByteEn);
                    if (eMemWrite) chk("memWData", owMemWData, eMemWData);
                end
            end
            if (eFDone) chk("fetchData", orIFetchData, eFData);
            if (eDDone) begin
                chk("dataRData", orDRData, eDData);
                chk("dataExc", orDException, eDExc);
            end
        end
    end

    // ---------------- memory responder ----------------
    int          ackDelay = 0;     // 0 = never ack
    logic [31:0] memWord = '0;
    bit          strayAck = 0;
    int          reqAge = 0;

    always @(posedge iwClk) begin
        #1;
        iwMemRData = memWord;
        if (owMemReq) begin
            reqAge++;
            iwMemAck = (ackDelay > 0) && (reqAge == ackDelay);
        end else begin
            reqAge = 0;
            iwMemAck = strayAck;
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic checkAllZero(input string tag);
        chk({tag, "_fDone"}, owIFetchDone, 0);
        chk({tag, "_fData"}, orIFetchData, 0);
        chk({tag, "_dDone"}, owDDone, 0);
        chk({tag, "_dData"}, orDRData, 0);
        chk({tag, "_dExc"}, orDException, EXCEPTION_SUCCESS);
        chk({tag, "_memReq"}, owMemReq, 0);
        chk({tag, "_memWrite"}, owMemWrite, 0);
        chk({tag, "_memAddr"}, owMemAddr, 0);
        chk({tag, "_memWData"}, owMemWData, 0);
        chk({tag, "_memBe"}, owMemByteEn, 0);
    endtask

    task automatic doData(input bit w, input logic [31:0] a, input logic [31:0] d, input logic [1:0] acc,
                          input bit sx, input int lat, input logic [31:0] word,
                          output logic [31:0] rd, output logic [3:0] exc, output int reqCyc,
                          output logic [31:0] mAddr, output logic [31:0] mWData, output logic [3:0] mBe);
        bit got;
        got = 0;
        @(posedge iwClk); #2;
        ackDelay = lat; memWord = word;
        iwDReq = 1; iwDWrite = w; iwDAddr = a; iwDWData = d; iwDAccess = acc; iwDSignExtend = sx;
        reqCyc = 0; rd = '0; exc = '0; mAddr = '0; mWData = '0; mBe = '0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge iwClk);
            if (owMemReq) begin
                reqCyc++; mAddr = owMemAddr; mWData = owMemWData; mBe = owMemByteEn;
            end
            if (owDDone) begin
                got = 1; rd = orDRData; exc = orDException;
            end
        end
        chk("dataDoneWithinBudget", got, 1);
        @(posedge iwClk); #2;
        iwDReq = 0;
    endtask

    task automatic doFetch(input logic [31:0] a, input int lat, input logic [31:0] word,
                           output logic [31:0] fd, output int reqCyc, output logic [31:0] mAddr);
        bit got;
        got = 0;
        @(posedge iwClk); #2;
        ackDelay = lat; memWord = word;
        iwIFetchReq = 1; iwIFetchAddr = a;
        reqCyc = 0; fd = '0; mAddr = '0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge iwClk);
            if (owMemReq) begin
                reqCyc++; mAddr = owMemAddr;
            end
            if (owIFetchDone) begin
                got = 1; fd = orIFetchData;
            end
        end
        chk("fetchDoneWithinBudget", got, 1);
        @(posedge iwClk); #2;
        iwIFetchReq = 0;
    endtask

    task automatic pulseReset();
        @(posedge iwClk); #2;
        iwnRst = 0;
        @(posedge iwClk); @(posedge iwClk); #2;
        iwnRst = 1;
    endtask

    logic [31:0] rd, mA, mW;
    logic [3:0]  exc, mB;
    int          rc;

    initial begin
        repeat (3) @(posedge iwClk);
        @(negedge iwClk);
        checkAllZero("reset");
        @(posedge iwClk); #2;
        iwnRst = 1;

        // word load, ack in the third cycle
        doData(0, 32'h100, 0, MEM_ACCESS_WORD, 0, 3, 32'hDEADBEEF, rd, exc, rc, mA, mW, mB);
        chk("lw_data", rd, 32'hDEADBEEF);
        chk("lw_exc", exc, EXCEPTION_SUCCESS);
        chk("lw_be", mB, 4'b1111);
        chk("lw_reqCycles", rc, 3);

        // signed and unsigned byte loads from lane 3
        doData(0, 32'h103, 0, MEM_ACCESS_BYTE, 1, 1, 32'h80123456, rd, exc, rc, mA, mW, mB);
        chk("lb_data", rd, 32'hFFFFFF80);
        chk("lb_be", mB, 4'b1000);
        doData(0, 32'h103, 0, MEM_ACCESS_BYTE, 0, 1, 32'h80123456, rd, exc, rc, mA, mW, mB);
        chk("lbu_data", rd, 32'h00000080);

        // halfword store to upper half
        doData(1, 32'h202, 32'h0000_1234, MEM_ACCESS_HALF_WORD, 0, 2, 32'h5555AAAA, rd, exc, rc, mA, mW, mB);
        chk("sh_addr", mA, 32'h200);
        chk("sh_be", mB, 4'b1100);
        chk("sh_wdata", mW, 32'h12341234);
        chk("sh_rdata", rd, 32'h0);

        // signed halfword load and byte store
        doData(0, 32'h102, 0, MEM_ACCESS_HALF_WORD, 1, 2, 32'h80011234, rd, exc, rc, mA, mW, mB);
        chk("lh_data", rd, 32'hFFFF8001);
        doData(1, 32'h101, 32'hFFFF_FFA5, MEM_ACCESS_BYTE, 0, 1, 32'h0, rd, exc, rc, mA, mW, mB);
        chk("sb_be", mB, 4'b0010);
        chk("sb_wdata", mW, 32'hA5A5A5A5);

        // plain fetch with minimum latency
        doFetch(32'h404, 1, 32'h00000013, rd, rc, mA);
        chk("fetch_data", rd, 32'h00000013);
        chk("fetch_addr", mA, 32'h404);

        // both requesters held: from reset data wins first, then strict alternation
        pulseReset();
        begin
            logic [3:0] order;
            int n;
            order = '0; n = 0;
            @(posedge iwClk); #2;
            ackDelay = 1; memWord = 32'h11223344;
            iwIFetchReq = 1; iwIFetchAddr = 32'h400;
            iwDReq = 1; iwDWrite = 0; iwDAddr = 32'h800; iwDAccess = MEM_ACCESS_WORD; iwDSignExtend = 0;
            for (int i = 0; i < 40 && n < 4; i++) begin
                @(negedge iwClk);
                if (owDDone)      begin order = {order[2:0], 1'b1}; n++; end
                if (owIFetchDone) begin order = {order[2:0], 1'b0}; n++; end
            end
            chk("rr_count", n, 4);
            chk("rr_order_DFDF", order, 4'b1010);
            @(posedge iwClk); #2;
            iwIFetchReq = 0; iwDReq = 0;
        end

        // timeouts on both sides
        doData(0, 32'h300, 0, MEM_ACCESS_WORD, 0, 0, 32'hFFFFFFFF, rd, exc, rc, mA, mW, mB);
        chk("to_reqCycles", rc, TO);
        chk("to_exc", exc, EXCEPTION_BUS_ERROR);
        chk("to_data", rd, 32'h0);
        doFetch(32'h500, 0, 32'hFFFFFFFF, rd, rc, mA);
        chk("to_fetch_data", rd, 32'h0);
        chk("to_fetch_reqCycles", rc, TO);

        // misaligned word load
        doData(0, 32'h101, 0, MEM_ACCESS_WORD, 0, 2, 32'hCAFEF00D, rd, exc, rc, mA, mW, mB);
`ifdef RV_MISALIGN_EXCEPTION_EN
        chk("lw_mis_exc", exc, EXCEPTION_MISALIGNED);
        chk("lw_mis_reqCycles", rc, 0);
        chk("lw_mis_data", rd, 32'h0);
`else
        chk("lw_mis_addr", mA, 32'h100);
        chk("lw_mis_data", rd, 32'hCAFEF00D);
        chk("lw_mis_exc", exc, EXCEPTION_SUCCESS);
`endif

        // reserved access size
        doData(0, 32'h100, 0, 2'b11, 0, 2, 32'h12345678, rd, exc, rc, mA, mW, mB);
        chk("rsv_exc", exc, EXCEPTION_ILLEGAL_INSTR);
        chk("rsv_reqCycles", rc, 0);
        chk("rsv_data", rd, 32'h0);

        // stray ack while idle
        begin
            int dones;
            dones = 0;
            @(posedge iwClk); #2;
            strayAck = 1;
            repeat (3) begin
                @(negedge iwClk);
                if (owDDone || owIFetchDone || owMemReq) dones++;
            end
            strayAck = 0;
            chk("strayAck_noActivity", dones, 0);
        end

        // reset in the middle of an access
        begin
            int dones;
            dones = 0;
            @(posedge iwClk); #2;
            ackDelay = 0;
            iwDReq = 1; iwDWrite = 0; iwDAddr = 32'h600; iwDAccess = MEM_ACCESS_WORD;
            repeat (3) @(posedge iwClk);
            #2;
            chk("midReset_busyBefore", owMemReq, 1);
            iwnRst = 0; iwDReq = 0;
            @(posedge iwClk);
            @(negedge iwClk);
            checkAllZero("midReset");
            @(posedge iwClk); #2;
            iwnRst = 1;
            repeat (6) begin
                @(negedge iwClk);
                if (owDDone || owIFetchDone) dones++;
            end
            chk("midReset_noDone", dones, 0);
        end

        repeat (2) @(posedge iwClk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
